// File: rtl/data_mem_responder_if.sv
// ============================================================================
// Module      : data_mem_responder_if
// Description : CPU-side data memory bus between the initiator and the
//               data memory responder.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

interface data_mem_responder_if;
    logic [31:0] addr;
    logic [1:0]  mem_width;
    logic        dispatch_read;
    logic        dispatch_write;
    logic [31:0] write_data;
    logic [31:0] read_data;
    logic        busy;
    logic        err_out;

    modport master (
        output addr, mem_width, dispatch_read, dispatch_write, write_data,
        input  read_data, busy, err_out
    );

    modport slave (
        input  addr, mem_width, dispatch_read, dispatch_write, write_data,
        output read_data, busy, err_out
    );
endinterface

`default_nettype wire

// File: rtl/data_mem_responder.sv
// ============================================================================
// Module      : data_mem_responder
// Description : Target end of the data memory bus. Turns one-cycle read/write
//               dispatches into BYTE/WORD/DWORD accesses on a byte-enabled
//               synchronous BRAM with configurable read latency.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module data_mem_responder #(
    parameter int ADDR_WIDTH   = 14,
    parameter int READ_LATENCY = 2
) (
    input  logic                  clk_in,
    input  logic                  rst_in,
    data_mem_responder_if.slave   bus,
    output logic [ADDR_WIDTH-1:0] bram_addr,
    output logic                  bram_en,
    output logic [3:0]            bram_we,
    output logic [31:0]           bram_din,
    input  logic [31:0]           bram_dout
);

    localparam logic [1:0] c_BYTE  = 2'd0;
    localparam logic [1:0] c_WORD  = 2'd1;

    localparam logic [1:0] c_S_IDLE       = 2'd0;
    localparam logic [1:0] c_S_RD_WAIT    = 2'd1;
    localparam logic [1:0] c_S_RD_CAPTURE = 2'd2;
    localparam logic [1:0] c_S_WR         = 2'd3;

    localparam logic [2:0] c_LATENCY = 3'(READ_LATENCY);

    logic [1:0]            r_state, w_state_nxt;
    logic [2:0]            r_count, w_count_nxt;
    logic [1:0]            r_lane, w_lane_nxt;
    logic [1:0]            r_width, w_width_nxt;
    logic                  r_oor, w_oor_nxt;
    logic [31:0]           r_read_data, w_read_data_nxt;
    logic                  r_err, w_err_nxt;
    logic [ADDR_WIDTH-1:0] w_bram_addr_nxt;
    logic                  w_bram_en_nxt;
    logic [3:0]            w_bram_we_nxt;
    logic [31:0]           w_bram_din_nxt;

    logic                  w_dispatch;
    logic                  w_misalign;
    logic                  w_oor;
    logic [1:0]            w_lane;
    logic [3:0]            w_size_mask;
    logic [31:0]           w_rd_mask;
    logic [31:0]           w_rd_shifted;

    assign w_dispatch = bus.dispatch_read | bus.dispatch_write;
    assign w_oor      = (bus.addr >> (ADDR_WIDTH + 2)) != 32'd0;

    // Misaligned WORD/DWORD addresses are forced down to their natural alignment.
    always_comb begin
        w_misalign  = 1'b0;
        w_lane      = 2'd0;
        w_size_mask = 4'b1111;
        case (bus.mem_width)
            c_BYTE: begin
                w_lane      = bus.addr[1:0];
                w_size_mask = 4'b0001;
            end
            c_WORD: begin
                w_misalign  = bus.addr[0];
                w_lane      = {bus.addr[1], 1'b0};
                w_size_mask = 4'b0011;
            end
            default: begin
                w_misalign  = bus.addr[1:0] != 2'd0;
            end
        endcase
    end

    always_comb begin
        w_rd_mask = 32'hFFFF_FFFF;
        case (r_width)
            c_BYTE:  w_rd_mask = 32'h0000_00FF;
            c_WORD:  w_rd_mask = 32'h0000_FFFF;
            default: w_rd_mask = 32'hFFFF_FFFF;
        endcase
    end

    assign w_rd_shifted = bram_dout >> {r_lane, 3'b000};

    always_comb begin
        w_state_nxt     = r_state;
        w_count_nxt     = r_count;
        w_lane_nxt      = r_lane;
        w_width_nxt     = r_width;
        w_oor_nxt       = r_oor;
        w_read_data_nxt = r_read_data;
        w_err_nxt       = r_err;
        w_bram_addr_nxt = bram_addr;
        w_bram_en_nxt   = bram_en;
        w_bram_we_nxt   = bram_we;
        w_bram_din_nxt  = bram_din;
        case (r_state)
            c_S_IDLE: begin
                if (w_dispatch) begin
                    w_lane_nxt      = w_lane;
                    w_width_nxt     = bus.mem_width;
                    w_oor_nxt       = w_oor;
                    w_bram_addr_nxt = bus.addr[ADDR_WIDTH+1:2];
                    w_bram_en_nxt   = 1'b1;
                    if ((bus.dispatch_read && bus.dispatch_write) || w_misalign || w_oor)
                        w_err_nxt = 1'b1;
                    // A write wins over a simultaneous read.
                    if (bus.dispatch_write) begin
                        w_bram_we_nxt  = w_oor ? 4'b0000 : (w_size_mask << w_lane);
                        w_bram_din_nxt = bus.write_data << {w_lane, 3'b000};
                        w_state_nxt    = c_S_WR;
                    end else begin
                        w_bram_we_nxt  = 4'b0000;
                        w_count_nxt    = c_LATENCY;
                        w_state_nxt    = c_S_RD_WAIT;
                    end
                end
            end
            c_S_RD_WAIT: begin
                w_bram_en_nxt = 1'b0;
                if (w_dispatch)
                    w_err_nxt = 1'b1;
                if (r_count == 3'd1)
                    w_state_nxt = c_S_RD_CAPTURE;
                w_count_nxt = r_count - 3'd1;
            end
            c_S_RD_CAPTURE: begin
                if (w_dispatch)
                    w_err_nxt = 1'b1;
                w_read_data_nxt = r_oor ? 32'd0 : (w_rd_shifted & w_rd_mask);
                w_state_nxt     = c_S_IDLE;
            end
            default: begin
                if (w_dispatch)
                    w_err_nxt = 1'b1;
                w_bram_en_nxt = 1'b0;
                w_bram_we_nxt = 4'b0000;
                w_state_nxt   = c_S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            r_state     <= c_S_IDLE;
            r_count     <= 3'd0;
            r_lane      <= 2'd0;
            r_width     <= 2'd0;
            r_oor       <= 1'b0;
            r_read_data <= 32'd0;
            r_err       <= 1'b0;
            bram_addr   <= '0;
            bram_en     <= 1'b0;
            bram_we     <= 4'b0000;
            bram_din    <= 32'd0;
        end else begin
            r_state     <= w_state_nxt;
            r_count     <= w_count_nxt;
            r_lane      <= w_lane_nxt;
            r_width     <= w_width_nxt;
            r_oor       <= w_oor_nxt;
            r_read_data <= w_read_data_nxt;
            r_err       <= w_err_nxt;
            bram_addr   <= w_bram_addr_nxt;
            bram_en     <= w_bram_en_nxt;
            bram_we     <= w_bram_we_nxt;
            bram_din    <= w_bram_din_nxt;
        end
    end

    assign bus.busy      = w_dispatch | (r_state != c_S_IDLE);
    assign bus.read_data = r_read_data;
    assign bus.err_out   = r_err;

endmodule

`default_nettype wire

// File: doc/data_mem_responder.md
Name: data_mem_responder

Overview:
- Responder (target) end of the data `memory_bus`.
- Accepts single-cycle `dispatch_read`/`dispatch_write` pulses from the CPU and drives `busy` and `read_data` back to it.
- Performs BYTE/WORD/DWORD accesses on a 32-bit-wide, byte-enabled, synchronous data BRAM with configurable read latency.
- Sits between `simple_proc`'s `mem_bus` and the data BRAM.

Parameters:
- ADDR_WIDTH, 14, BRAM word-address width. Byte space is 2^(ADDR_WIDTH+2).
- READ_LATENCY, 2, cycles from BRAM address/enable to valid bram_dout. Legal range 1..7.

Ports:
- clk_in  input  1  system clock.
- rst_in  input  1  reset, asynchronous, active-low.
- addr  input  32  byte address from initiator.
- mem_width  input  2  mem::BYTE=0, mem::WORD=1 (16b), mem::DWORD=2 (32b).
- dispatch_read  input  1  one-cycle read request.
- dispatch_write  input  1  one-cycle write request.
- write_data  input  32  store data, right-justified.
- read_data  output  32  load data, right-justified, zero-filled above access width.
- busy  output  1  access in progress.
- err_out  output  1  sticky protocol/address error.
- bram_addr  output  ADDR_WIDTH  BRAM word address (registered).
- bram_en  output  1  BRAM enable (registered).
- bram_we  output  4  BRAM byte write enables (registered).
- bram_din  output  32  BRAM write data, lane-shifted (registered).
- bram_dout  input  32  BRAM read data.

Behaviour:
- Reset (rst_in=0, asynchronous): state=IDLE, counter=0, read_data=0, err_out=0, bram_en=0, bram_we=0, bram_addr=0, bram_din=0.
- A reset mid-access abandons the access. No BRAM write is issued after reset asserts.
- busy is combinational: dispatch_read | dispatch_write | (state!=IDLE).
  - Consequence: busy is already high in the cycle the dispatch pulse is seen. The initiator samples busy in that same cycle.
- Lane and alignment:
  - lane=addr[1:0]; word=addr[ADDR_WIDTH+1:2].
  - Misaligned accesses (WORD with addr[0]=1; DWORD with addr[1:0]!=0) are forced down to alignment and set err_out.
  - Out of range (addr[31:ADDR_WIDTH+2]!=0): write dropped (bram_we stays 0), read returns 0, err_out set. The transaction still completes with normal timing.
- FSM: IDLE, RD_WAIT, RD_CAPTURE, WR.
- IDLE + dispatch_write:
  - Register bram_addr=word and bram_en=1.
  - Byte enables: BYTE → bram_we=1<<lane; WORD → 4'b0011<<lane; DWORD → 4'b1111.
  - bram_din = write_data << (8*lane).
  - Go to WR.
- WR (1 cycle): BRAM commits. Clear bram_en and bram_we, go to IDLE. busy falls in the next cycle.
  - Total busy for a write = 2 cycles.
- IDLE + dispatch_read: register bram_addr=word, bram_en=1, bram_we=0, counter=READ_LATENCY. Go to RD_WAIT.
- RD_WAIT: bram_en=0. Decrement counter; at counter==1 go to RD_CAPTURE.
- RD_CAPTURE:
  - Set read_data = (bram_dout >> 8*lane) masked to the access width: BYTE 0x000000FF, WORD 0x0000FFFF, DWORD all ones.
  - Go to IDLE.
  - read_data is valid in the first cycle busy is low and holds until the next read capture. Writes never change read_data.
- Lane, width and the out-of-range decision are latched at dispatch; inputs are don't-care afterwards.
- Simultaneous dispatch_read and dispatch_write: the write executes, the read is discarded, err_out is set.
- A dispatch while state!=IDLE is ignored and sets err_out.
- err_out clears only on reset.
- No sign extension here; the initiator performs it.

Test Plan:
1. DWORD write 0xDEADBEEF @0x10, then DWORD read @0x10:
   - Write: bram_we=4'hF, bram_addr=4, busy high exactly 2 cycles.
   - Read: read_data=0xDEADBEEF, busy high READ_LATENCY+2 cycles.
2. BYTE write 0xAB @0x13 over word 0x11223344:
   - bram_we=4'b1000, bram_din[31:24]=0xAB.
   - DWORD read @0x10 returns 0xAB223344. BYTE read @0x13 returns 0x000000AB.
3. WORD read @0x12 of 0xAB223344 returns 0x0000AB22.
   - WORD read @0x11 returns 0x00003344 (forced down to 0x10) and sets err_out=1.
4. Simultaneous dispatch_read and dispatch_write of 0x55 to @0x20: only the write occurs, read_data is unchanged, err_out=1.
   - A second dispatch during RD_WAIT is ignored.
5. Write @0x0001_0000 (out of range with ADDR_WIDTH=14): bram_we stays 0, err_out=1.
   - A read there returns 0 after normal latency.
6. Assert rst_in low during RD_WAIT and during WR:
   - busy drops immediately once the dispatch pulse has ended; the pulse itself holds busy high regardless of reset.
   - bram_we=0, read_data=0, err_out=0.
   - The next DWORD read after release returns the pre-existing BRAM contents.
